// File: rtl/sonar_pkg.sv
// sonar_pkg: shared FSM encoding and result constants for the sonar ranger.
package sonar_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_CONVERT,
    S_DONE,
    S_HOLDOFF
  } state_e;
  localparam logic [13:0] SAT_CM      = 14'd9999;
  localparam logic [15:0] TIMEOUT_BCD = 16'h9999;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 14-bit binary to 4 BCD digits in 14 clocks.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);
  logic [29:0] sr_q, sr_d, adj;
  logic [3:0]  cnt_q;
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 4; i++)
      adj[14+4*i +: 4] = sr_q[14+4*i +: 4] >= 4'd5 ? sr_q[14+4*i +: 4] + 4'd3 : sr_q[14+4*i +: 4];
    sr_d = start ? {16'b0, bin} : cnt_q != 4'd0 ? {adj[28:0], 1'b0} : sr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= start ? 4'd14 : cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    end
  // done rides with the final shift so the result is settled on the following cycle
  assign done = cnt_q == 4'd1;
  assign bcd  = sr_q[29:14];
endmodule

// File: rtl/sonar_distance_bcd.sv
// sonar_distance_bcd: HC-SR04 trigger/echo timer producing a BCD centimetre distance.
module sonar_distance_bcd
  import sonar_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TRIG_US      = 10,
  parameter int US_PER_CM    = 58,
  parameter int TIMEOUT_US   = 25000,
  parameter int PERIOD_MS    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance,
  output logic        distance_valid,
  output logic        timeout,
  output logic        busy
);
  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int TRIG_CYC  = TRIG_US * CLK_FREQ_MHZ;
  localparam int PW = $clog2(CLK_FREQ_MHZ + 1);
  localparam int SW = $clog2(US_PER_CM + 1);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int QW = $clog2(PERIOD_US + 1);
  localparam int CW = $clog2(TRIG_CYC + 1);
  state_e        state_q;
  logic [2:0]    sync_q;
  logic [PW-1:0] presc_q;
  logic [SW-1:0] sub_q, sub_d;
  logic [13:0]   cm_q, cm_d;
  logic [TW-1:0] to_q;
  logic [QW-1:0] pc_q;
  logic [CW-1:0] tc_q;
  logic          to_flag_q;
  logic          tick, rise, fall, sub_wrap, to_hit, period_hit, start_trig, conv_start, conv_done;
  logic [15:0]   bcd;
  always_comb begin
    tick       = state_q != S_IDLE && presc_q == PW'(CLK_FREQ_MHZ - 1);
    rise       = sync_q[1] & ~sync_q[2];
    fall       = ~sync_q[1] & sync_q[2];
    sub_wrap   = tick && sub_q == SW'(US_PER_CM - 1);
    sub_d      = sub_wrap ? '0 : sub_q + SW'(tick);
    cm_d       = sub_wrap && cm_q != SAT_CM ? cm_q + 14'd1 : cm_q;
    to_hit     = tick && to_q == TW'(TIMEOUT_US - 1);
    period_hit = pc_q == QW'(PERIOD_US) || (tick && pc_q == QW'(PERIOD_US - 1));
    start_trig = enable && (state_q == S_IDLE || (state_q == S_HOLDOFF && period_hit));
    conv_start = state_q == S_MEASURE && fall;
  end
  // cm_d feeds the converter so a tick on the falling-edge cycle is not lost
  bin2bcd_seq u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(conv_start),
    .bin  (cm_d),
    .done (conv_done),
    .bcd  (bcd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      presc_q        <= '0;
      sub_q          <= '0;
      cm_q           <= '0;
      to_q           <= '0;
      pc_q           <= '0;
      tc_q           <= '0;
      to_flag_q      <= 1'b0;
      trig           <= 1'b0;
      distance       <= '0;
      distance_valid <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sync_q         <= {sync_q[1:0], echo};
      presc_q        <= state_q == S_IDLE || tick ? '0 : presc_q + PW'(1);
      pc_q           <= tick && pc_q != QW'(PERIOD_US) ? pc_q + QW'(1) : pc_q;
      distance_valid <= 1'b0;
      if (start_trig) begin
        state_q <= S_TRIG;
        trig    <= 1'b1;
        busy    <= 1'b1;
        tc_q    <= '0;
        pc_q    <= '0;
      end else
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_TRIG:
            if (tc_q == CW'(TRIG_CYC - 1)) begin
              state_q   <= S_WAIT_RISE;
              trig      <= 1'b0;
              to_q      <= '0;
              to_flag_q <= 1'b0;
            end else tc_q <= tc_q + CW'(1);
          S_WAIT_RISE: begin
            to_q <= to_q + TW'(tick);
            if (to_hit) begin
              state_q   <= S_DONE;
              to_flag_q <= 1'b1;
            end else if (rise) begin
              state_q <= S_MEASURE;
              sub_q   <= '0;
              cm_q    <= '0;
            end
          end
          S_MEASURE: begin
            to_q  <= to_q + TW'(tick);
            sub_q <= sub_d;
            cm_q  <= cm_d;
            if (fall) state_q <= S_CONVERT;
            else if (to_hit) begin
              state_q   <= S_DONE;
              to_flag_q <= 1'b1;
            end
          end
          S_CONVERT: if (conv_done) state_q <= S_DONE;
          S_DONE: begin
            distance       <= to_flag_q ? TIMEOUT_BCD : bcd;
            timeout        <= to_flag_q;
            distance_valid <= 1'b1;
            busy           <= 1'b0;
            state_q        <= S_HOLDOFF;
          end
          S_HOLDOFF: if (period_hit) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sonar_distance_bcd.sv
// tb_sonar_distance_bcd: randomized echo stimulus checked against a cycle-level behavioural model.
module tb_sonar_distance_bcd;
  localparam int CF = 2, TU = 3, UPC = 3, TO = 600, PMS = 1;
  localparam int TRIG_CYC = TU * CF, PER_CYC = PMS * 1000 * CF;
  localparam int TUB = 1, UPCB = 1, TOB = 10200, PMSB = 11;
  localparam int PER_B = PMSB * 1000 * CF;
  logic clk = 0, rst, en_a, echo_a, trig_a, val_a, to_a, busy_a;
  logic rst_b, en_b, echo_b, trig_b, val_b, to_b, busy_b;
  logic [15:0] dist_a, dist_b;
  int n_pass = 0, n_total = 0, cyc = 0;
  bit pend = 0, pend_to, ev, done_b = 0, last_to = 0;
  int pend_at;
  logic [15:0] pend_d, last_d = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sonar_distance_bcd #(.CLK_FREQ_MHZ(CF), .TRIG_US(TU), .US_PER_CM(UPC), .TIMEOUT_US(TO), .PERIOD_MS(PMS)) dut (
    .clk(clk), .rst(rst), .enable(en_a), .echo(echo_a), .trig(trig_a),
    .distance(dist_a), .distance_valid(val_a), .timeout(to_a), .busy(busy_a));
  sonar_distance_bcd #(.CLK_FREQ_MHZ(CF), .TRIG_US(TUB), .US_PER_CM(UPCB), .TIMEOUT_US(TOB), .PERIOD_MS(PMSB)) dut_s (
    .clk(clk), .rst(rst_b), .enable(en_b), .echo(echo_b), .trig(trig_b),
    .distance(dist_b), .distance_valid(val_b), .timeout(to_b), .busy(busy_b));
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = v > 9999 ? 9999 : v;
    return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction
  // Per-cycle model check: the strobe appears only on the predicted cycle, results hold otherwise
  always @(negedge clk) begin
    if (rst) begin
      last_d  = 0;
      last_to = 0;
    end else begin
      ev = pend && cyc == pend_at;
      chk("valid_strobe", val_a, ev);
      if (ev) begin
        chk("distance", dist_a, pend_d);
        chk("timeout", to_a, pend_to);
        last_d  = pend_d;
        last_to = pend_to;
      end else begin
        chk("distance_hold", dist_a, last_d);
        chk("timeout_hold", to_a, last_to);
      end
      if (pend && cyc >= pend_at) pend = 0;
    end
  end
  task automatic wait_trig_a(input int bound);
    int k = 0;
    while (!trig_a && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("trig_rise_seen", trig_a, 1);
  endtask
  initial begin
    int prev, rise, w, f, d, wu, mode, k, seen;
    int dir_w[3] = '{2, 5, 300};
    logic [15:0] dir_e[3] = '{16'h0000, 16'h0001, 16'h0100};
    rst = 1; en_a = 0; echo_a = 0; prev = -1;
    repeat (3) @(posedge clk); #1;
    chk("rst_trig", trig_a, 0); chk("rst_distance", dist_a, 0); chk("rst_valid", val_a, 0);
    chk("rst_timeout", to_a, 0); chk("rst_busy", busy_a, 0);
    rst = 0; en_a = 1;
    @(posedge clk); #1;
    chk("trig_after_idle_exit", trig_a, 1);
    for (int i = 0; i < 16; i++) begin
      wait_trig_a(PER_CYC + 100);
      rise = cyc;
      if (prev >= 0) chk("trig_period", rise - prev, PER_CYC);
      prev = rise;
      chk("busy_in_trig", busy_a, 1);
      w = 0;
      while (trig_a && w < 1000) begin
        @(posedge clk); #1;
        w++;
      end
      chk("trig_width", w, TRIG_CYC);
      f = cyc;
      mode = i < 3 ? 0 : i == 3 ? 1 : i == 4 ? 2 : ($urandom_range(0, 9) < 7 ? 0 : $urandom_range(1, 2));
      wu = i < 3 ? dir_w[i] : $urandom_range(1, 400);
      d = $urandom_range(1, 30);
      if (mode != 0) begin
        pend_at = f + TO * CF + 1; pend_d = 16'h9999; pend_to = 1; pend = 1;
      end
      repeat (d) @(posedge clk); #1;
      if (mode != 1) echo_a = 1;
      if (mode == 0) begin
        repeat (wu * CF) @(posedge clk); #1;
        echo_a = 0;
        pend_at = cyc + 18; pend_d = i < 3 ? dir_e[i] : to_bcd(wu / UPC); pend_to = 0; pend = 1;
      end
      k = 0;
      while (pend && k < 3000) begin
        @(posedge clk); #1;
        k++;
      end
      echo_a = 0;
    end
    en_a = 0; seen = 0;
    repeat (PER_CYC + 100) begin
      @(posedge clk); #1;
      if (trig_a) seen = 1;
    end
    chk("no_trig_when_disabled", seen, 0);
    chk("busy_idle", busy_a, 0);
    en_a = 1;
    @(posedge clk); #1;
    chk("trig_on_reenable", trig_a, 1);
    @(posedge clk); #1;
    rst = 1; #1;
    chk("async_rst_trig", trig_a, 0); chk("async_rst_busy", busy_a, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("trig_after_rst_release", trig_a, 1);
    k = 0;
    while (trig_a && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(posedge clk); #1;
    echo_a = 1;
    repeat (40) @(posedge clk); #1;
    chk("busy_in_measure", busy_a, 1);
    rst = 1; #1;
    chk("rst_measure_trig", trig_a, 0); chk("rst_measure_distance", dist_a, 0);
    chk("rst_measure_valid", val_a, 0); chk("rst_measure_timeout", to_a, 0);
    chk("rst_measure_busy", busy_a, 0);
    pend = 0; echo_a = 0; en_a = 0;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    repeat (200) @(posedge clk); #1;
    k = 0;
    while (!done_b && k < 60000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("sat_bench_finished", done_b, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    int k, rise, prevb, t0;
    int wb[2] = '{1234, 10050};
    logic [15:0] eb[2] = '{16'h1234, 16'h9999};
    rst_b = 1; en_b = 0; echo_b = 0; prevb = 0;
    repeat (3) @(posedge clk); #1;
    rst_b = 0; en_b = 1;
    for (int j = 0; j < 2; j++) begin
      k = 0;
      while (!trig_b && k < PER_B + 100) begin
        @(posedge clk); #1;
        k++;
      end
      chk("b_trig_rise", trig_b, 1);
      rise = cyc;
      if (j == 1) chk("b_period", rise - prevb, PER_B);
      prevb = rise;
      k = 0;
      while (trig_b && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      repeat (3) @(posedge clk); #1;
      echo_b = 1;
      repeat (wb[j] * CF) @(posedge clk); #1;
      echo_b = 0;
      t0 = cyc; k = 0;
      while (!val_b && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      chk("b_latency", cyc - t0, 18);
      chk("b_distance", dist_b, eb[j]);
      chk("b_timeout", to_b, 0);
      @(posedge clk); #1;
      chk("b_single_strobe", val_b, 0);
    end
    en_b = 0;
    done_b = 1;
  end
endmodule
